// File: rtl/pwm_timebase_cmp.sv
// PWM time base: prescaled edge/centre-aligned counter with shadowed auto-reload
// and start/end compares. Optional repetition counter enabled by PWM_TB_REPCNT_EN.
module pwm_timebase_cmp #(
   parameter int CNT_WIDTH = 16,
   parameter int REP_WIDTH = 8
) (
   input  logic                 clk_psc_i,
   input  logic                 rst_i,
   input  logic                 cnt_en_i,
   input  logic                 cnt_mode_i,
   input  logic                 preload_en_i,
   input  logic                 sw_update_i,
   input  logic [CNT_WIDTH-1:0] arr_preload_i,
   input  logic [CNT_WIDTH-1:0] cmp_start_pre_i,
   input  logic [CNT_WIDTH-1:0] cmp_end_pre_i,
   input  logic [REP_WIDTH-1:0] rep_preload_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 dir_o,
   output logic                 cmp_start_eq_o,
   output logic                 cmp_start_gt_o,
   output logic                 cmp_end_eq_o,
   output logic                 cmp_end_gt_o,
   output logic                 update_event_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] arr_q, arr_d;
   logic [CNT_WIDTH-1:0] cs_q, cs_d;
   logic [CNT_WIDTH-1:0] ce_q, ce_d;
   logic                 dir_q, dir_d;
   logic                 uev_q, uev_d;

   logic [CNT_WIDTH-1:0] cnt_inc, cnt_dec, step_cnt;
   logic                 step_dir;
   logic                 wrap;
   logic                 upd;

   assign cnt_inc = cnt_q + CNT_WIDTH'(1);
   assign cnt_dec = cnt_q - CNT_WIDTH'(1);

   // Candidate step for an enabled cycle; centre mode with a zero period degrades to edge mode.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      step_cnt = cnt_q;
      step_dir = 1'b0;
      if (cnt_mode_i && (arr_q != '0)) begin
         if (!dir_q) begin
            step_cnt = cnt_inc;
            step_dir = (cnt_inc >= arr_q);
         end else begin
            step_cnt = cnt_dec;
            step_dir = (cnt_dec != '0);
         end
      end else begin
         step_cnt = (cnt_q >= arr_q) ? '0 : cnt_inc;
      end
   end

   assign wrap = cnt_en_i && (step_cnt == '0);

`ifdef PWM_TB_REPCNT_EN
   logic [REP_WIDTH-1:0] rep_q, rep_d;

   assign upd = wrap && (rep_q == '0);

   always_comb begin
      rep_d = rep_q;
      if (sw_update_i || upd) begin
         rep_d = rep_preload_i;
      end else if (wrap) begin
         rep_d = rep_q - REP_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_psc_i) begin
      if (rst_i) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end
`else
   logic unused_rep;
   assign unused_rep = ^rep_preload_i;
   assign upd        = wrap;
`endif

   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      uev_d = 1'b0;
      // With preload disabled the active registers simply follow the preloads.
      arr_d = preload_en_i ? arr_q : arr_preload_i;
      cs_d  = preload_en_i ? cs_q  : cmp_start_pre_i;
      ce_d  = preload_en_i ? ce_q  : cmp_end_pre_i;
      if (sw_update_i) begin
         cnt_d = '0;
         dir_d = 1'b0;
         uev_d = 1'b1;
         arr_d = arr_preload_i;
         cs_d  = cmp_start_pre_i;
         ce_d  = cmp_end_pre_i;
      end else if (cnt_en_i) begin
         cnt_d = step_cnt;
         dir_d = step_dir;
         if (upd) begin
            uev_d = 1'b1;
            arr_d = arr_preload_i;
            cs_d  = cmp_start_pre_i;
            ce_d  = cmp_end_pre_i;
         end
      end
   end

   always_ff @(posedge clk_psc_i) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (rst_i) begin
         cnt_q <= '0;
         dir_q <= 1'b0;
         uev_q <= 1'b0;
         arr_q <= '0;
         cs_q  <= '0;
         ce_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         dir_q <= dir_d;
         uev_q <= uev_d;
         arr_q <= arr_d;
         cs_q  <= cs_d;
         ce_q  <= ce_d;
      end
   end

   // A compare value beyond the period top is never reached, so it is masked.
   logic start_valid, end_valid;
   assign start_valid = (cs_q <= arr_q);
   assign end_valid   = (ce_q <= arr_q);

   assign cnt_o          = cnt_q;
   assign dir_o          = dir_q;
   assign update_event_o = uev_q;
   assign cmp_start_eq_o = start_valid && (cnt_q == cs_q);
   assign cmp_start_gt_o = start_valid && (cnt_q >  cs_q);
   assign cmp_end_eq_o   = end_valid   && (cnt_q == ce_q);
   assign cmp_end_gt_o   = end_valid   && (cnt_q >  ce_q);

endmodule

// File: tb/tb_pwm_timebase_cmp.sv
// Testbench for pwm_timebase_cmp: directed scenarios plus randomized stimulus,
// all checked against a cycle reference model (repetition modelled with PWM_TB_REPCNT_EN).
module tb_pwm_timebase_cmp;
   localparam int CW = 16;
   localparam int RW = 8;

   logic          clk = 1'b0;
   logic          rst, en, mode, pe, sw;
   logic [CW-1:0] arr_pre, cs_pre, ce_pre;
   logic [RW-1:0] rep_pre;
   logic [CW-1:0] cnt;
   logic          dir, s_eq, s_gt, e_eq, e_gt, uev;

   always #5 clk = ~clk;

   pwm_timebase_cmp #(.CNT_WIDTH(CW), .REP_WIDTH(RW)) dut (
      .clk_psc_i       (clk),
      .rst_i           (rst),
      .cnt_en_i        (en),
      .cnt_mode_i      (mode),
      .preload_en_i    (pe),
      .sw_update_i     (sw),
      .arr_preload_i   (arr_pre),
      .cmp_start_pre_i (cs_pre),
      .cmp_end_pre_i   (ce_pre),
      .rep_preload_i   (rep_pre),
      .cnt_o           (cnt),
      .dir_o           (dir),
      .cmp_start_eq_o  (s_eq),
      .cmp_start_gt_o  (s_gt),
      .cmp_end_eq_o    (e_eq),
      .cmp_end_gt_o    (e_gt),
      .update_event_o  (uev)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state, plain integers.
   int m_cnt, m_arr, m_cs, m_ce, m_rep;
   int m_dir, m_uev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_load();
      m_arr = int'(arr_pre);
      m_cs  = int'(cs_pre);
      m_ce  = int'(ce_pre);
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_update();
      int n;
      int d;
      int u;
      if (rst) begin
         m_cnt = 0; m_dir = 0; m_arr = 0; m_cs = 0; m_ce = 0; m_rep = 0; m_uev = 0;
         return;
      end
      if (sw) begin
         m_cnt = 0; m_dir = 0; m_uev = 1; m_rep = int'(rep_pre);
         model_load();
         return;
      end
      n = m_cnt; d = m_dir; u = 0;
      if (en) begin
         if (mode && m_arr > 0) begin
            if (m_dir == 0) begin
               n = m_cnt + 1;
               d = (n >= m_arr) ? 1 : 0;
            end else begin
               n = m_cnt - 1;
               d = (n != 0) ? 1 : 0;
            end
         end else begin
            n = (m_cnt >= m_arr) ? 0 : m_cnt + 1;
            d = 0;
         end
         if (n == 0) begin
`ifdef PWM_TB_REPCNT_EN
            if (m_rep == 0) begin
               u = 1;
               m_rep = int'(rep_pre);
            end else begin
               m_rep = m_rep - 1;
            end
`else
            u = 1;
`endif
         end
      end
      m_cnt = n; m_dir = d; m_uev = u;
      if (!pe || u == 1) model_load();
   endtask

   task automatic compare_model();
      check("cnt",      32'(cnt),  32'(m_cnt));
      check("dir",      32'(dir),  32'(m_dir));
      check("uev",      32'(uev),  32'(m_uev));
      check("start_eq", 32'(s_eq), 32'((m_cnt == m_cs && m_cs <= m_arr) ? 1 : 0));
      check("start_gt", 32'(s_gt), 32'((m_cnt >  m_cs && m_cs <= m_arr) ? 1 : 0));
      check("end_eq",   32'(e_eq), 32'((m_cnt == m_ce && m_ce <= m_arr) ? 1 : 0));
      check("end_gt",   32'(e_gt), 32'((m_cnt >  m_ce && m_ce <= m_arr) ? 1 : 0));
   endtask

   task automatic cycle();
      model_update();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic sw_pulse();
      sw = 1'b1;
      cycle();
      sw = 1'b0;
   endtask

   initial begin
      int c2[6];
      int d2[6];
      int t3a[11];
      int t3b[6];
      c2  = '{1, 2, 3, 2, 1, 0};
      d2  = '{0, 0, 1, 1, 1, 0};
      t3a = '{3, 4, 0, 1, 2, 3, 4, 5, 6, 7, 0};
      t3b = '{3, 4, 5, 6, 7, 0};

      rst = 1'b1; en = 1'b0; mode = 1'b0; pe = 1'b1; sw = 1'b0;
      arr_pre = '0; cs_pre = '0; ce_pre = '0; rep_pre = '0;
      cycle();
      cycle();
      check("rst_cnt",      32'(cnt),  0);
      check("rst_dir",      32'(dir),  0);
      check("rst_uev",      32'(uev),  0);
      check("rst_start_eq", 32'(s_eq), 1);
      check("rst_start_gt", 32'(s_gt), 0);

      // Edge mode, arr=4, start=1, end=3.
      rst = 1'b0; en = 1'b1; mode = 1'b0; pe = 1'b1;
      arr_pre = 16'd4; cs_pre = 16'd1; ce_pre = 16'd3;
      sw_pulse();
      check("t1_sw_cnt", 32'(cnt), 0);
      check("t1_sw_uev", 32'(uev), 1);
      for (int i = 1; i <= 10; i++) begin
         cycle();
         check("t1_cnt",      32'(cnt),  32'(i % 5));
         check("t1_uev",      32'(uev),  32'((i % 5 == 0) ? 1 : 0));
         check("t1_start_eq", 32'(s_eq), 32'((i % 5 == 1) ? 1 : 0));
         check("t1_start_gt", 32'(s_gt), 32'((i % 5 >= 2) ? 1 : 0));
         check("t1_end_eq",   32'(e_eq), 32'((i % 5 == 3) ? 1 : 0));
         check("t1_end_gt",   32'(e_gt), 32'((i % 5 == 4) ? 1 : 0));
      end

      // Centre mode, arr=3.
      mode = 1'b1; arr_pre = 16'd3;
      sw_pulse();
      for (int i = 0; i < 12; i++) begin
         cycle();
         check("t2_cnt", 32'(cnt), 32'(c2[i % 6]));
         check("t2_dir", 32'(dir), 32'(d2[i % 6]));
         check("t2_uev", 32'(uev), 32'((i % 6 == 5) ? 1 : 0));
      end

      // Shadowed arr write mid-period.
      mode = 1'b0; pe = 1'b1; arr_pre = 16'd4;
      sw_pulse();
      cycle();
      cycle();
      arr_pre = 16'd7;
      for (int i = 0; i < 11; i++) begin
         cycle();
         check("t3_shadow_cnt", 32'(cnt), 32'(t3a[i]));
      end
      // Immediate arr write mid-period.
      arr_pre = 16'd4;
      sw_pulse();
      cycle();
      cycle();
      pe = 1'b0; arr_pre = 16'd7;
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("t3_immed_cnt", 32'(cnt), 32'(t3b[i]));
         check("t3_immed_uev", 32'(uev), 32'((i == 5) ? 1 : 0));
      end

      // Software update while disabled.
      pe = 1'b1; arr_pre = 16'd4; cs_pre = 16'd1;
      sw_pulse();
      cycle(); cycle(); cycle();
      check("t4_pre_cnt", 32'(cnt), 3);
      en = 1'b0; arr_pre = 16'd6; cs_pre = 16'd2; ce_pre = 16'd5;
      sw_pulse();
      check("t4_sw_cnt", 32'(cnt), 0);
      check("t4_sw_uev", 32'(uev), 1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t4_hold_cnt", 32'(cnt), 0);
         check("t4_hold_uev", 32'(uev), 0);
      end
      en = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         cycle();
         check("t4_new_cnt",      32'(cnt),  32'(i % 7));
         check("t4_new_start_eq", 32'(s_eq), 32'((i % 7 == 2) ? 1 : 0));
      end

      // Repetition: edge arr=1, rep_preload=2.
      arr_pre = 16'd1; rep_pre = 8'd2;
      sw_pulse();
      for (int i = 1; i <= 12; i++) begin
         cycle();
`ifdef PWM_TB_REPCNT_EN
         check("t5_uev", 32'(uev), 32'((i % 6 == 0) ? 1 : 0));
`else
         check("t5_uev", 32'(uev), 32'((i % 2 == 0) ? 1 : 0));
`endif
      end

      // Reset during centre down phase.
      mode = 1'b1; arr_pre = 16'd5;
      sw_pulse();
      for (int i = 0; i < 7; i++) cycle();
      check("t6_pre_cnt", 32'(cnt), 3);
      check("t6_pre_dir", 32'(dir), 1);
      rst = 1'b1;
      cycle();
      check("t6_cnt",    32'(cnt),  0);
      check("t6_dir",    32'(dir),  0);
      check("t6_uev",    32'(uev),  0);
      check("t6_end_eq", 32'(e_eq), 1);
      check("t6_end_gt", 32'(e_gt), 0);
      rst = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         sw  = ($urandom_range(0, 39) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 39) == 0) mode = ~mode;
         if ($urandom_range(0, 49) == 0) pe = ~pe;
         if ($urandom_range(0, 7) == 0) arr_pre = 16'($urandom_range(0, 9));
         if ($urandom_range(0, 7) == 0) cs_pre  = 16'($urandom_range(0, 11));
         if ($urandom_range(0, 7) == 0) ce_pre  = 16'($urandom_range(0, 11));
         if ($urandom_range(0, 15) == 0) rep_pre = 8'($urandom_range(0, 3));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
